// File: rtl/spawn_placer_if.sv
`default_nettype none
// ============================================================================
// Module   : spawn_placer_if
// Purpose  : Groups the request, RNG, occupancy-map and result handshake
//            signals of the spawn placer. master = placer side,
//            slave = surrounding game logic side.
// Revision : 1.0 - initial release
// ============================================================================
interface spawn_placer_if #(
  parameter int IDX_W   = 12,
  parameter int COORD_W = 6
);
  logic               spawn_req;
  logic [IDX_W-1:0]   rng_in;
  logic               occ_rd;
  logic [IDX_W-1:0]   occ_addr;
  logic               occ_hit;
  logic               spawn_valid;
  logic               spawn_ready;
  logic [IDX_W-1:0]   spawn_idx;
  logic [COORD_W-1:0] spawn_col;
  logic [COORD_W-1:0] spawn_row;
  logic               spawn_fail;
  logic               busy;

  modport master (
    input  spawn_req, rng_in, occ_hit, spawn_ready,
    output occ_rd, occ_addr, spawn_valid, spawn_idx, spawn_col, spawn_row,
           spawn_fail, busy
  );

  modport slave (
    output spawn_req, rng_in, occ_hit, spawn_ready,
    input  occ_rd, occ_addr, spawn_valid, spawn_idx, spawn_col, spawn_row,
           spawn_fail, busy
  );
endinterface
`default_nettype wire

// File: rtl/spawn_placer.sv
`default_nettype none
// ============================================================================
// Module   : spawn_placer
// Purpose  : Finds a free grid cell for a new object. Tries MAX_TRIES random
//            candidates against the occupancy map, then falls back to a
//            wrapping linear scan; reports failure when the grid is full.
// Revision : 1.0 - initial release
// ============================================================================
module spawn_placer #(
  parameter int GRID_COLS = 40,
  parameter int GRID_ROWS = 40,
  parameter int IDX_W     = 12,
  parameter int COORD_W   = 6,
  parameter int MAX_TRIES = 8
) (
  input  wire logic      clk,
  input  wire logic      reset,
  spawn_placer_if.master sp
);

  localparam int c_cells  = GRID_COLS * GRID_ROWS;
  localparam int c_try_w  = $clog2(MAX_TRIES + 1);
  localparam int c_scan_w = $clog2(c_cells + 1);
  localparam logic [IDX_W-1:0]    c_cells_v = IDX_W'(c_cells);
  localparam logic [IDX_W-1:0]    c_last    = IDX_W'(c_cells - 1);
  localparam logic [c_try_w-1:0]  c_max_try = c_try_w'(MAX_TRIES);
  localparam logic [c_scan_w-1:0] c_scan_end = c_scan_w'(c_cells);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SAMPLE = 3'd1,
    S_READ   = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

  state_t              r_state, w_state;
  logic                r_mode, w_mode;          // 0 = random phase, 1 = scan phase
  logic [c_try_w-1:0]  r_tries, w_tries;
  logic [c_scan_w-1:0] r_scan_cnt, w_scan_cnt;
  logic [IDX_W-1:0]    r_cand, w_cand;
  logic                r_occ_rd, w_occ_rd;
  logic [IDX_W-1:0]    r_occ_addr, w_occ_addr;
  logic                r_valid, w_valid;
  logic [IDX_W-1:0]    r_idx, w_idx;
  logic [COORD_W-1:0]  r_col, w_col;
  logic [COORD_W-1:0]  r_row, w_row;
  logic                r_fail, w_fail;

  logic [c_try_w-1:0]  w_tries_inc;
  logic [IDX_W-1:0]    w_cand_inc;
  logic                w_rng_oob;
  logic [COORD_W-1:0]  w_cand_col;
  logic [COORD_W-1:0]  w_cand_row;

  assign w_tries_inc = r_tries + 1'b1;
  // Wrapping successor; anything at or past the last cell restarts at 0.
  assign w_cand_inc  = (r_cand >= c_last) ? '0 : r_cand + 1'b1;
  assign w_rng_oob   = (sp.rng_in >= c_cells_v);
  // Constant divide/modulo on the registered candidate, captured on DONE entry.
  assign w_cand_col  = COORD_W'(r_cand % GRID_COLS);
  assign w_cand_row  = COORD_W'(r_cand / GRID_COLS);

  // Next-state and next-output computation for the search controller.
  always_comb begin
    w_state    = r_state;
    w_mode     = r_mode;
    w_tries    = r_tries;
    w_scan_cnt = r_scan_cnt;
    w_cand     = r_cand;
    w_occ_rd   = 1'b0;
    w_occ_addr = r_occ_addr;
    w_valid    = r_valid;
    w_idx      = r_idx;
    w_col      = r_col;
    w_row      = r_row;
    w_fail     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (sp.spawn_req) begin
          w_state = S_SAMPLE;
          w_tries = '0;
          w_mode  = 1'b0;
        end
      end

      S_SAMPLE: begin
        w_cand = sp.rng_in;
        if (w_rng_oob) begin
          w_tries = w_tries_inc;
          if (w_tries_inc == c_max_try) begin
            // Out-of-range last sample wraps: the scan starts at cell 0.
            w_mode     = 1'b1;
            w_scan_cnt = c_scan_w'(1);
            w_cand     = '0;
            w_occ_addr = '0;
            w_occ_rd   = 1'b1;
            w_state    = S_READ;
          end
        end else begin
          w_occ_addr = sp.rng_in;
          w_occ_rd   = 1'b1;
          w_state    = S_READ;
        end
      end

      S_READ: begin
        w_state = S_CHECK;
      end

      S_CHECK: begin
        if (!sp.occ_hit) begin
          w_idx   = r_cand;
          w_col   = w_cand_col;
          w_row   = w_cand_row;
          w_valid = 1'b1;
          w_state = S_DONE;
        end else if (!r_mode) begin
          w_tries = w_tries_inc;
          if (w_tries_inc == c_max_try) begin
            w_mode     = 1'b1;
            w_scan_cnt = c_scan_w'(1);
            w_cand     = w_cand_inc;
            w_occ_addr = w_cand_inc;
            w_occ_rd   = 1'b1;
            w_state    = S_READ;
          end else begin
            w_state = S_SAMPLE;
          end
        end else if (r_scan_cnt == c_scan_end) begin
          w_fail  = 1'b1;
          w_state = S_FAIL;
        end else begin
          w_scan_cnt = r_scan_cnt + 1'b1;
          w_cand     = w_cand_inc;
          w_occ_addr = w_cand_inc;
          w_occ_rd   = 1'b1;
          w_state    = S_READ;
        end
      end

      S_DONE: begin
        if (sp.spawn_ready) begin
          w_valid = 1'b0;
          w_state = S_IDLE;
        end
      end

      S_FAIL: begin
        w_state = S_IDLE;
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State and output registers; active-low synchronous reset aborts any search.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_mode     <= 1'b0;
      r_tries    <= '0;
      r_scan_cnt <= '0;
      r_cand     <= '0;
      r_occ_rd   <= 1'b0;
      r_occ_addr <= '0;
      r_valid    <= 1'b0;
      r_idx      <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_fail     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_mode     <= w_mode;
      r_tries    <= w_tries;
      r_scan_cnt <= w_scan_cnt;
      r_cand     <= w_cand;
      r_occ_rd   <= w_occ_rd;
      r_occ_addr <= w_occ_addr;
      r_valid    <= w_valid;
      r_idx      <= w_idx;
      r_col      <= w_col;
      r_row      <= w_row;
      r_fail     <= w_fail;
    end
  end

  assign sp.occ_rd      = r_occ_rd;
  assign sp.occ_addr    = r_occ_addr;
  assign sp.spawn_valid = r_valid;
  assign sp.spawn_idx   = r_idx;
  assign sp.spawn_col   = r_col;
  assign sp.spawn_row   = r_row;
  assign sp.spawn_fail  = r_fail;
  assign sp.busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spawn_placer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spawn_placer
// Purpose  : Self-checking bench for spawn_placer with an occupancy-map model
//            and a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spawn_placer;

  localparam int IDX_W   = 12;
  localparam int COORD_W = 6;
  localparam int CELLS   = 1600;

  typedef struct {
    bit fail;
    int idx;
    int col;
    int row;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  spawn_placer_if #(.IDX_W(IDX_W), .COORD_W(COORD_W)) sp ();

  spawn_placer #(
    .GRID_COLS(40), .GRID_ROWS(40), .IDX_W(IDX_W), .COORD_W(COORD_W), .MAX_TRIES(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .sp   (sp)
  );

  bit             occ [CELLS];
  int             n_checks = 0;
  int             n_errors = 0;
  int             reads = 0;
  int             valid_cycles = 0;
  int             fail_cycles = 0;
  int             rd_base = 0;
  int             rng_base = 0;
  int             rng_step = 0;
  logic [IDX_W-1:0] read_log [$];
  exp_t           sb [$];

  // Clock generation.
  always #5 clk = ~clk;

  // Random source: a base value optionally advanced by each read of this test.
  assign sp.rng_in = IDX_W'(rng_base + rng_step * (reads - rd_base));

  // Occupancy map model: answer one cycle after the read strobe.
  always @(posedge clk)
    sp.occ_hit <= (sp.occ_rd && sp.occ_addr < CELLS) ? occ[sp.occ_addr] : 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Monitor: log reads, count pulses, compare results against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      sb.delete();
    end else begin
      if (sp.occ_rd) begin
        reads++;
        read_log.push_back(sp.occ_addr);
      end
      if (sp.spawn_valid) valid_cycles++;
      if (sp.spawn_fail)  fail_cycles++;
      if ((sp.spawn_valid && sp.spawn_ready) || sp.spawn_fail) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          check_eq("res_fail", sp.spawn_fail, e.fail);
          if (!e.fail) begin
            check_eq("res_idx", sp.spawn_idx, e.idx);
            check_eq("res_col", sp.spawn_col, e.col);
            check_eq("res_row", sp.spawn_row, e.row);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_occ(input bit v);
    for (int i = 0; i < CELLS; i++) occ[i] = v;
  endtask

  task automatic push_ok(input int idx);
    exp_t e;
    e.fail = 1'b0;
    e.idx  = idx;
    e.col  = idx % 40;
    e.row  = idx / 40;
    sb.push_back(e);
  endtask

  task automatic push_fail();
    exp_t e;
    e.fail = 1'b1;
    e.idx  = 0;
    e.col  = 0;
    e.row  = 0;
    sb.push_back(e);
  endtask

  task automatic pulse_req();
    sp.spawn_req = 1'b1;
    tick();
    sp.spawn_req = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles && sp.busy; i++) tick();
    check_eq(tag, sp.busy, 0);
  endtask

  function automatic logic [63:0] all_outs();
    return {sp.occ_rd, sp.occ_addr, sp.spawn_valid, sp.spawn_idx,
            sp.spawn_col, sp.spawn_row, sp.spawn_fail, sp.busy};
  endfunction

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Main stimulus sequence.
  initial begin
    int vstart;
    bit stable;
    sp.spawn_req   = 1'b0;
    sp.spawn_ready = 1'b1;
    fill_occ(1'b0);
    repeat (3) tick();
    check_eq("reset_outs", all_outs(), 0);
    reset = 1'b1;
    tick();

    // Empty map, candidate 1234: fixed latency and coordinate conversion.
    rd_base = reads; rng_base = 1234; rng_step = 0;
    push_ok(1234);
    pulse_req();
    tick();
    check_eq("t1_rd", sp.occ_rd, 1);
    check_eq("t1_addr", sp.occ_addr, 1234);
    tick();
    check_eq("t1_rd_clear", sp.occ_rd, 0);
    check_eq("t1_valid_early", sp.spawn_valid, 0);
    tick();
    check_eq("t1_valid_e3", sp.spawn_valid, 1);
    wait_idle("t1_idle", 20);
    check_eq("t1_reads", reads - rd_base, 1);

    // First three candidates occupied, fourth free.
    fill_occ(1'b0);
    occ[5] = 1'b1; occ[6] = 1'b1; occ[7] = 1'b1;
    rd_base = reads; rng_base = 5; rng_step = 1;
    push_ok(8);
    pulse_req();
    wait_idle("t2_idle", 100);
    check_eq("t2_reads", reads - rd_base, 4);
    check_eq("t2_last_addr", read_log[rd_base + 3], 8);

    // All random tries hit ending at 1599; scan wraps to free cell 0.
    fill_occ(1'b1);
    occ[0] = 1'b0;
    rd_base = reads; rng_base = 1592; rng_step = 1;
    push_ok(0);
    pulse_req();
    wait_idle("t3_idle", 200);
    check_eq("t3_reads", reads - rd_base, 9);
    check_eq("t3_last_random", read_log[rd_base + 7], 1599);
    check_eq("t3_scan_first", read_log[rd_base + 8], 0);

    // Full map: 8 random reads plus 1600 scan reads, then one fail pulse.
    fill_occ(1'b1);
    rd_base = reads; rng_base = 100; rng_step = 0;
    vstart = valid_cycles;
    fail_cycles = 0;
    push_fail();
    pulse_req();
    wait_idle("t4_idle", 6000);
    check_eq("t4_reads", reads - rd_base, 8 + CELLS);
    check_eq("t4_scan_first", read_log[rd_base + 8], 101);
    check_eq("t4_scan_last", read_log[rd_base + 8 + CELLS - 1], 100);
    check_eq("t4_fail_pulses", fail_cycles, 1);
    check_eq("t4_no_valid", valid_cycles - vstart, 0);

    // Back-pressure: result held stable, requests ignored while held.
    fill_occ(1'b0);
    rd_base = reads; rng_base = 777; rng_step = 0;
    sp.spawn_ready = 1'b0;
    push_ok(777);
    pulse_req();
    for (int i = 0; i < 20 && !sp.spawn_valid; i++) tick();
    check_eq("t5_valid", sp.spawn_valid, 1);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sp.spawn_req = i[0];
      tick();
      if (!(sp.spawn_valid && sp.spawn_idx == 777 && sp.spawn_col == 17 &&
            sp.spawn_row == 19 && sp.busy)) stable = 1'b0;
    end
    sp.spawn_req = 1'b0;
    check_eq("t5_hold_stable", stable, 1);
    check_eq("t5_no_new_reads", reads - rd_base, 1);
    sp.spawn_ready = 1'b1;
    sp.spawn_req   = 1'b1;
    tick();
    sp.spawn_req = 1'b0;
    check_eq("t5_valid_drop", sp.spawn_valid, 0);
    check_eq("t5_idle", sp.busy, 0);
    tick();
    check_eq("t5_req_ignored", sp.busy, 0);

    // Reset while in READ during the scan phase.
    fill_occ(1'b1);
    rd_base = reads; rng_base = 10; rng_step = 0;
    push_fail();
    pulse_req();
    for (int i = 0; i < 200 && !(sp.occ_rd && (reads - rd_base) >= 10); i++) tick();
    check_eq("t6_in_scan_read", sp.occ_rd, 1);
    reset = 1'b0;
    tick();
    check_eq("t6_reset_outs", all_outs(), 0);
    reset = 1'b1;
    tick();

    // Out-of-range sample counts as a miss with no read, then a normal result.
    fill_occ(1'b0);
    rd_base = reads; rng_base = 4095; rng_step = 0;
    push_ok(50);
    pulse_req();
    tick();
    check_eq("t7_oob_no_rd", sp.occ_rd, 0);
    check_eq("t7_oob_busy", sp.busy, 1);
    rng_base = 50;
    tick();
    check_eq("t7_rd", sp.occ_rd, 1);
    check_eq("t7_addr", sp.occ_addr, 50);
    wait_idle("t7_idle", 20);
    check_eq("t7_reads", reads - rd_base, 1);

    tick();
    check_eq("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
